// File: rtl/ml_token_sequencer_if.sv
// ml_token_sequencer_if
//   Bundles the host-side handshakes, the array boundary and the error
//   controls of ml_token_sequencer into one interface.
//
//   Handshake rule for both in_* and res_*: a transfer happens on a rising
//   clock edge where valid and ready are both high. The sender holds valid and
//   its data stable until that edge. The receiver may raise or drop ready at
//   any time.
//
//   Signals (WIDTH dual-rail lanes):
//     in_valid / in_ready / in_data[WIDTH]     host word into the sequencer
//     res_valid / res_ready / res_data[WIDTH]  decoded result to the consumer
//     cell_reset                               active-high reset to the array cells
//     cell_in[2*WIDTH]                         dual-rail drive to the array
//     cell_out[2*WIDTH]                        dual-rail result from the array (asynchronous)
//     err / err_clr                            sticky error flag and its clear
//
//   Modports:
//     slave  - the sequencer itself
//     master - the surroundings: host, consumer and array together
interface ml_token_sequencer_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               cell_reset;
  logic [2*WIDTH-1:0] cell_in;
  logic [2*WIDTH-1:0] cell_out;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic               err;
  logic               err_clr;

  modport slave (
    input  in_valid, in_data, cell_out, res_ready, err_clr,
    output in_ready, cell_reset, cell_in, res_valid, res_data, err
  );

  modport master (
    output in_valid, in_data, cell_out, res_ready, err_clr,
    input  in_ready, cell_reset, cell_in, res_valid, res_data, err
  );
endinterface

// File: rtl/ml_token_sequencer.sv
// ml_token_sequencer
//   Feeds host words into an asynchronous Morphle Logic cell array as
//   dual-rail tokens. It runs the four-phase cycle: data token, wait for a
//   complete result, capture, spacer, wait for all-empty. The sequencer also
//   owns the array's cell reset.
//
//   Lane code: 00 empty, 01 logic 0, 10 logic 1, 11 illegal.
//
//   Ports:
//     clk        system clock
//     reset_n    asynchronous active-low reset
//     bus        ml_token_sequencer_if.slave (host, consumer, array, error)
//     dbg_state  current FSM state, for observation only
//
//   Parameters: WIDTH lanes, RST_CYCLES cell-reset length, TIMEOUT
//   watchdog limit.
//
//   Optional feature: define ML_WATCHDOG_EN to time the SETTLE, DRIVE and
//   SPACER waits. A wait that reaches TIMEOUT cycles is treated like an
//   illegal code. Without the macro those states wait indefinitely.
module ml_token_sequencer #(
  parameter int WIDTH      = 4,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  ml_token_sequencer_if.slave bus,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {ARST, SETTLE, IDLE, DRIVE, HOLD, SPACER, ERR} state_t;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

  if (RST_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("ml_token_sequencer: RST_CYCLES and TIMEOUT must be >= 1");
  end

  state_t             state_q, state_n;
  logic [RC_W-1:0]    rst_cnt_q, rst_cnt_n;
  logic               cell_reset_q, cell_reset_n;
  logic [2*WIDTH-1:0] cell_in_q, cell_in_n;
  logic               in_ready_q, in_ready_n;
  logic               res_valid_q, res_valid_n;
  logic [WIDTH-1:0]   res_data_q, res_data_n;
  logic               err_q, err_n;
  logic [2*WIDTH-1:0] sync1_q, sync2_q;

  logic               all_full, all_empty, any_ill, go_err;
  logic [2*WIDTH-1:0] enc;
  logic [WIDTH-1:0]   dec;

`ifdef ML_WATCHDOG_EN
  localparam int WD_RAW = $clog2(TIMEOUT + 1);
  localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);
  logic [WD_W-1:0] wd_q, wd_n;
  logic            wd_timed;
`endif

  // Lane classification on the synchronized result, plus host-word encoding.
  always_comb begin
    all_full = 1'b1;
    any_ill  = 1'b0;
    enc      = '0;
    dec      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      all_full = all_full & (sync2_q[2*i] | sync2_q[2*i+1]);
      any_ill  = any_ill | (sync2_q[2*i] & sync2_q[2*i+1]);
      enc[2*i +: 2] = bus.in_data[i] ? 2'b10 : 2'b01;
      dec[i]        = (sync2_q[2*i +: 2] == 2'b10);
    end
  end

  assign all_empty = ~|sync2_q;

  always_comb begin
    state_n      = state_q;
    rst_cnt_n    = rst_cnt_q;
    cell_reset_n = cell_reset_q;
    cell_in_n    = cell_in_q;
    in_ready_n   = 1'b0;
    res_valid_n  = res_valid_q;
    res_data_n   = res_data_q;
    err_n        = err_q;
    go_err       = 1'b0;

    case (state_q)
      ARST: begin
        if (rst_cnt_q == RC_LAST) begin
          cell_reset_n = 1'b0;
          rst_cnt_n    = '0;
          state_n      = SETTLE;
        end else begin
          rst_cnt_n = rst_cnt_q + 1'b1;
        end
      end
      SETTLE: if (all_empty) state_n = IDLE;
      IDLE: begin
        // in_ready is registered. It rises the cycle after IDLE is entered,
        // which keeps a spacer between any two accepted words.
        if (bus.in_valid && in_ready_q) begin
          cell_in_n = enc;
          state_n   = DRIVE;
        end else begin
          in_ready_n = 1'b1;
        end
      end
      DRIVE: begin
        // A partly filled word is still in flight, so keep waiting.
        if (any_ill) go_err = 1'b1;
        else if (all_full) begin
          res_data_n  = dec;
          res_valid_n = 1'b1;
          state_n     = HOLD;
        end
      end
      HOLD: begin
        if (any_ill) go_err = 1'b1;
        else if (res_valid_q && bus.res_ready) begin
          res_valid_n = 1'b0;
          cell_in_n   = '0;
          state_n     = SPACER;
        end
      end
      SPACER: begin
        if (any_ill) go_err = 1'b1;
        else if (all_empty) state_n = IDLE;
      end
      ERR: begin
        if (bus.err_clr) begin
          err_n     = 1'b0;
          rst_cnt_n = '0;
          state_n   = ARST;
        end
      end
      default: begin
        cell_reset_n = 1'b1;
        rst_cnt_n    = '0;
        state_n      = ARST;
      end
    endcase

`ifdef ML_WATCHDOG_EN
    wd_timed = (state_q == SETTLE) || (state_q == DRIVE) || (state_q == SPACER);
    if (wd_timed && (wd_q == WD_W'(TIMEOUT - 1))) go_err = 1'b1;
`endif

    if (go_err) begin
      err_n        = 1'b1;
      res_valid_n  = 1'b0;
      cell_in_n    = '0;
      cell_reset_n = 1'b1;
      state_n      = ERR;
    end

`ifdef ML_WATCHDOG_EN
    if (state_n != state_q) wd_n = '0;
    else if (wd_timed)      wd_n = wd_q + 1'b1;
    else                    wd_n = wd_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ARST;
      rst_cnt_q    <= '0;
      cell_reset_q <= 1'b1;
      cell_in_q    <= '0;
      in_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      err_q        <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
    end else begin
      state_q      <= state_n;
      rst_cnt_q    <= rst_cnt_n;
      cell_reset_q <= cell_reset_n;
      cell_in_q    <= cell_in_n;
      in_ready_q   <= in_ready_n;
      res_valid_q  <= res_valid_n;
      res_data_q   <= res_data_n;
      err_q        <= err_n;
      sync1_q      <= bus.cell_out;
      sync2_q      <= sync1_q;
    end
  end

`ifdef ML_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wd_q <= '0;
    else          wd_q <= wd_n;
  end
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.cell_reset = cell_reset_q;
  assign bus.cell_in    = cell_in_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.err        = err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ml_token_sequencer.sv
`timescale 1ns/1ps
module tb_ml_token_sequencer;
  localparam int W  = 4;
  localparam int DW = 2 * W;
`ifdef ML_WATCHDOG_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 255;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  ml_token_sequencer_if #(.WIDTH(W)) bus ();

  ml_token_sequencer #(.WIDTH(W), .RST_CYCLES(4), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- array model ----------------
  // The model echoes cell_in after echo_dly falling edges.
  // arr_mode 0: echo. 1: never responds. 2: echo with lane 2 forced to 11
  // while a token is driven.
  int echo_dly = 3;
  int arr_mode = 0;
  int zero_run = 0;
  logic [DW-1:0] hist [16];

  initial begin
    for (int k = 0; k < 16; k++) hist[k] = '0;
    bus.cell_out = '0;
  end

  always @(negedge clk) begin
    logic [DW-1:0] o;
    for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = bus.cell_in;
    o = hist[echo_dly];
    if (arr_mode == 1) o = '0;
    if (arr_mode == 2 && bus.cell_in != '0) o[5:4] = 2'b11;
    bus.cell_out = o;
    zero_run = (o == '0) ? zero_run + 1 : 0;
  end

  // ---------------- reference helpers ----------------
  // Dual-rail word: lane i carries value 2 for a one and 1 for a zero,
  // weighted by 4**i.
  function automatic logic [DW-1:0] encode(input logic [W-1:0] d);
    int v;
    v = 0;
    for (int i = 0; i < W; i++) v += (d[i] ? 2 : 1) * (4 ** i);
    return v[DW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_in_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 300) begin step(); n++; end
    check(tag, 32'(n < 300), 1);
  endtask

  task automatic drive_word(input logic [W-1:0] d);
    wait_in_ready("in_ready_wait");
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    exp_q.push_back(d);
    check("cell_in_drive", bus.cell_in, encode(d));
    check("in_ready_drop", bus.in_ready, 0);
  endtask

  // Completes a transaction whose word was already driven. Called right after
  // drive_word, it measures latency in edges from the accept edge.
  task automatic finish_txn(input logic [W-1:0] d, input int rdy_pct,
                            input int exp_lat, input int hold);
    int lat;
    bit done, first;
    logic [W-1:0] e;
    lat = 1; done = 0; first = 1;
    while (!done && lat < 3000) begin
      if (bus.res_valid) begin
        if (first && exp_lat > 0) check("latency", lat, exp_lat);
        if (first && hold > 0) begin
          bus.in_valid = 1'b1;
          bus.in_data  = ~d;
          for (int h = 0; h < hold; h++) begin
            bus.res_ready = 1'b0;
            step();
            check("bp_valid", bus.res_valid, 1);
            check("bp_data", bus.res_data, d);
            check("bp_cell_in", bus.cell_in, encode(d));
            check("bp_in_ready", bus.in_ready, 0);
          end
          bus.in_valid = 1'b0;
        end
        first = 0;
        bus.res_ready = ($urandom_range(99) < rdy_pct);
        if (bus.res_ready) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check("res_data", bus.res_data, e);
          check("cell_in_hold", bus.cell_in, encode(d));
          done = 1;
        end
      end
      step();
      lat++;
    end
    bus.res_ready = 1'b0;
    if (!done) begin
      check("res_timeout", 0, 1);
    end else begin
      check("res_valid_drop", bus.res_valid, 0);
      check("spacer_cell_in", bus.cell_in, 0);
      wait_in_ready("spacer_wait");
      // The array must read empty for at least the sync depth plus the
      // IDLE entry before the host is offered the next slot.
      check("spacer_gap", 32'(zero_run >= 4), 1);
    end
  endtask

  task automatic run_txn(input logic [W-1:0] d, input int rdy_pct,
                         input int exp_lat, input int hold);
    drive_word(d);
    finish_txn(d, rdy_pct, exp_lat, hold);
  endtask

  task automatic pulse_err_clr_and_recover(input string tag);
    int c;
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check({tag, "_err_cleared"}, bus.err, 0);
    check({tag, "_no_accept"}, bus.cell_in, 0);
    c = 0;
    while (bus.cell_reset && c < 20) begin c++; step(); end
    check({tag, "_rst_cycles"}, c, 4);
    wait_in_ready({tag, "_ready"});
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    int c, n;
    bit seen_valid;
    logic [W-1:0] d;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0; bus.err_clr = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_cell_reset", bus.cell_reset, 1);
    check("rst_cell_in", bus.cell_in, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_err", bus.err, 0);

    // Reset release: cell_reset 4 cycles, in_ready on cycle 6.
    reset_n = 1'b1;
    c = 0; seen_valid = 0;
    while (bus.cell_reset && c < 20) begin c++; step(); seen_valid |= bus.res_valid; end
    check("rst_hold_cycles", c, 4);
    while (!bus.in_ready && c < 20) begin c++; step(); seen_valid |= bus.res_valid; end
    check("in_ready_cycle", c, 6);
    check("no_res_after_rst", seen_valid, 0);

    // Directed 1010 with echo after 3 cycles.
    echo_dly = 3;
    run_txn(4'b1010, 100, 0, 0);

    // Minimum latency with an immediate echo.
    repeat (8) step();
    echo_dly = 0;
    run_txn(4'b0110, 100, 4, 0);

    // Backpressure for 20 cycles.
    repeat (8) step();
    echo_dly = 3;
    run_txn(4'b1010, 100, 0, 20);

    // err_clr outside ERR changes nothing.
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("clr_idle_err", bus.err, 0);
    check("clr_idle_ready", bus.in_ready, 1);
    check("clr_idle_cell_reset", bus.cell_reset, 0);

    // Illegal code on lane 2 during DRIVE.
    drive_word(4'b0011);
    arr_mode = 2;
    n = 0;
    while (!bus.err && n < 10) begin step(); n++; end
    check("ill_err_latency", 32'(n >= 3 && n <= 4), 1);
    check("ill_cell_in", bus.cell_in, 0);
    check("ill_cell_reset", bus.cell_reset, 1);
    check("ill_res_valid", bus.res_valid, 0);
    check("ill_in_ready", bus.in_ready, 0);
    exp_q.delete();
    arr_mode = 0;
    step();
    // err_clr and in_valid together: the clear wins and nothing is taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 4'b1111;
    pulse_err_clr_and_recover("ill");
    bus.in_valid = 1'b0;
    run_txn(4'b1001, 100, 0, 0);

    // Array that never responds.
    arr_mode = 1;
    drive_word(4'b1100);
`ifdef ML_WATCHDOG_EN
    n = 1;
    while (!bus.err && n < 40) begin step(); n++; end
    check("wd_latency", 32'(n >= 9 && n <= 13), 1);
    check("wd_cell_in", bus.cell_in, 0);
    check("wd_cell_reset", bus.cell_reset, 1);
    exp_q.delete();
    arr_mode = 0;
    repeat (4) step();
    pulse_err_clr_and_recover("wd");
`else
    repeat (1000) step();
    check("nowd_err", bus.err, 0);
    check("nowd_res_valid", bus.res_valid, 0);
    check("nowd_in_ready", bus.in_ready, 0);
    check("nowd_cell_in", bus.cell_in, encode(4'b1100));
    arr_mode = 0;
    finish_txn(4'b1100, 100, 0, 0);
`endif

    // Reset asserted in HOLD.
    drive_word(4'b0101);
    n = 0;
    while (!bus.res_valid && n < 50) begin step(); n++; end
    check("hold_reached", bus.res_valid, 1);
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_cell_reset", bus.cell_reset, 1);
    check("mid_rst_cell_in", bus.cell_in, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_res_data", bus.res_data, 0);
    check("mid_rst_err", bus.err, 0);
    exp_q.delete();
    repeat (3) step();
    reset_n = 1'b1;
    run_txn(4'b0101, 100, 0, 0);

    // Random traffic: random words, array delays and consumer stalls.
    for (int t = 0; t < 40; t++) begin
      repeat (8) step();
      echo_dly = $urandom_range(0, 6);
      d = W'($urandom);
      run_txn(d, $urandom_range(20, 100), (echo_dly == 0) ? 4 : 0, 0);
    end

    check("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
